bram_req_arbiter: RTL

//  Request arbiter directly upstream of the BRAM controller (10-cycle fixed-latency, non-burst BRAM).

---
 rtl/bram_pkg.sv | 23 ++
 rtl/bram_outst_cnt.sv | 37 +++
 rtl/bram_req_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/bram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bram_pkg: shared widths, requester select codes, command struct  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bram_pkg;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 32;
  localparam int BRAM_LATENCY = 10;

  localparam logic SEL_DMA = 1'b0;
  localparam logic SEL_CPU = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] di;
    logic              sel;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/bram_outst_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bram_outst_cnt: in-flight read counter, saturating at 0 and MAX  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bram_outst_cnt #(
  parameter int MAX_OUTST = 10,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] r_cnt;

  // Simultaneous inc/dec cancel; a decrement at zero is a stale return and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != c_max_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == c_max_cnt);

endmodule
`default_nettype wire

// File: rtl/bram_req_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bram_req_arbiter: DMA/CPU round-robin merge onto one BRAM port   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bram_req_arbiter
  import bram_pkg::*;
#(
  parameter int ADDR_W    = bram_pkg::ADDR_W,
  parameter int DATA_W    = bram_pkg::DATA_W,
  parameter int MAX_OUTST = 10,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_we,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              bram_in_valid,
  output logic              bram_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  output logic              bram_reader_sel,
  input  logic              bram_dma_rvalid,
  input  logic              bram_cpu_rvalid,
  output logic [CNT_W-1:0]  dma_outst,
  output logic [CNT_W-1:0]  cpu_outst
);

  logic r_last;
  logic r_valid;
  cmd_t r_cmd;

  logic w_dma_full, w_cpu_full;
  logic w_dma_elig, w_cpu_elig;
  logic w_dma_gnt,  w_cpu_gnt;

  // Writes consume no return-buffer slot, so they bypass the credit check.
  assign w_dma_elig = dma_req_valid & (dma_req_we | ~w_dma_full);
  assign w_cpu_elig = cpu_req_valid & ~w_cpu_full;

  assign w_cpu_gnt = rst_n & w_cpu_elig & (~w_dma_elig | (r_last == SEL_DMA));
  assign w_dma_gnt = rst_n & w_dma_elig & (~w_cpu_elig | (r_last == SEL_CPU));

  assign dma_req_ready = w_dma_gnt;
  assign cpu_req_ready = w_cpu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_last  <= SEL_DMA;
    end else begin
      r_valid <= w_dma_gnt | w_cpu_gnt;
      if (w_dma_gnt) begin
        r_cmd  <= '{wr: dma_req_we, addr: dma_req_addr, di: dma_req_wdata, sel: SEL_DMA};
        r_last <= SEL_DMA;
      end else if (w_cpu_gnt) begin
        r_cmd  <= '{wr: 1'b0, addr: cpu_req_addr, di: '0, sel: SEL_CPU};
        r_last <= SEL_CPU;
      end
    end
  end

  assign bram_in_valid   = r_valid;
  assign bram_wr         = r_cmd.wr;
  assign bram_addr       = r_cmd.addr;
  assign bram_di         = r_cmd.di;
  assign bram_reader_sel = r_cmd.sel;

  bram_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_dma_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_dma_gnt & ~dma_req_we),
    .i_dec  (bram_dma_rvalid),
    .o_cnt  (dma_outst),
    .o_full (w_dma_full)
  );

  bram_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cpu_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_cpu_gnt),
    .i_dec  (bram_cpu_rvalid),
    .o_cnt  (cpu_outst),
    .o_full (w_cpu_full)
  );

endmodule
`default_nettype wire
